// File: rtl/data_memory_controller.sv
// ============================================================================
//  Module      : data_memory_controller
//  Description : Sequential bridge between the load/store byte-enable stage
//                and a valid/ready data-memory bus. One access per
//                instruction, core stalled until completion, load data
//                returned right-aligned to the addressed byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // core side
    input  logic                  memory_read,
    input  logic                  memory_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_mask,
    input  logic                  misaligned,
    output logic [31:0]           read_data,
    output logic                  stall,
    output logic                  done,
    output logic                  access_fault,
    // bus request channel
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_write,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic [31:0]           bus_req_wdata,
    output logic [3:0]            bus_req_wstrb,
    // bus response channel
    input  logic                  bus_resp_valid,
    input  logic [31:0]           bus_resp_rdata,
    input  logic                  bus_resp_error
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // One extra bit so the compare cannot wrap when the limit equals the
    // counter's maximum value.
    localparam logic [TIMEOUT_WIDTH:0] c_TIMEOUT = (TIMEOUT_WIDTH+1)'(TIMEOUT_CYCLES);
    localparam logic                   c_TO_EN   = (TIMEOUT_CYCLES != 0);

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic [TIMEOUT_WIDTH:0]   w_cnt_next;

    logic                     r_write;
    logic [ADDR_WIDTH-1:0]    r_addr;   // already word aligned
    logic [1:0]               r_off;    // byte offset within the word
    logic [31:0]              r_wdata;
    logic [3:0]               r_wstrb;
    logic [31:0]              r_rdata;
    logic                     r_fault;

    logic w_go;
    logic w_busy;
    logic w_timeout;
    logic w_to_exit;
    logic w_resp;
    logic w_req_active;

    // A store with no strobes does nothing, so it never reaches the bus.
    assign w_go       = ~misaligned & (memory_read | (memory_write & (|write_mask)));
    assign w_busy     = (r_state == c_REQ) | (r_state == c_RESP);
    assign w_cnt_next = {1'b0, r_cnt} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
    assign w_timeout  = c_TO_EN & w_busy & (w_cnt_next >= c_TIMEOUT);
    assign w_resp     = (r_state == c_RESP) & bus_resp_valid;

    // A handshake or response in the limit cycle takes precedence over the
    // timeout, so an accepted request is never orphaned on the bus.
    assign w_to_exit  = w_timeout &
                        (((r_state == c_REQ)  & ~bus_req_ready) |
                         ((r_state == c_RESP) & ~bus_resp_valid));

    // Next-state selection for the access sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (w_go) w_state_next = c_REQ;
            c_REQ: begin
                if (bus_req_ready)  w_state_next = c_RESP;
                else if (w_timeout) w_state_next = c_DONE;
            end
            c_RESP: begin
                if (bus_resp_valid) w_state_next = c_DONE;
                else if (w_timeout) w_state_next = c_DONE;
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_IDLE;
        else          r_state <= w_state_next;
    end

    // Timeout counter: runs in REQ/RESP, holds at the limit, clears otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_cnt <= '0;
        else if (!w_busy)    r_cnt <= '0;
        else if (!w_timeout) r_cnt <= w_cnt_next[TIMEOUT_WIDTH-1:0];
    end

    // Capture the access when it is launched; loads carry no data or strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_off   <= 2'b00;
            r_wdata <= '0;
            r_wstrb <= 4'b0000;
        end else if ((r_state == c_IDLE) && w_go) begin
            r_write <= ~memory_read;
            r_addr  <= {address[ADDR_WIDTH-1:2], 2'b00};
            r_off   <= address[1:0];
            r_wdata <= memory_read ? 32'h0 : write_data;
            r_wstrb <= memory_read ? 4'b0000 : write_mask;
        end
    end

    // Completion results; read data only changes on an error-free load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_resp) begin
            r_fault <= bus_resp_error;
            if (!r_write && !bus_resp_error)
                r_rdata <= bus_resp_rdata >> {r_off, 3'b000};
        end else if (w_to_exit) begin
            r_fault <= 1'b1;
        end
    end

    assign w_req_active  = (r_state == c_REQ);

    assign bus_req_valid = w_req_active;
    assign bus_req_write = w_req_active & r_write;
    assign bus_req_addr  = w_req_active ? r_addr  : '0;
    assign bus_req_wdata = w_req_active ? r_wdata : 32'h0;
    assign bus_req_wstrb = w_req_active ? r_wstrb : 4'b0000;

    // Stall is combinational in IDLE so the core holds in the launch cycle;
    // masked by reset so every output reads zero while reset is asserted.
    assign stall        = reset_n & (((r_state == c_IDLE) & w_go) | w_busy);
    assign done         = (r_state == c_DONE);
    assign read_data    = r_rdata;
    assign access_fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_controller.sv
// ============================================================================
//  Module      : tb_data_memory_controller
//  Description : Directed self-checking bench for data_memory_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, mis = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  mask = '0;
    logic        ready = 1'b0, rvalid = 1'b0, rerr = 1'b0;
    logic [31:0] rdata = '0;

    logic [31:0] read_data, bwdata, baddr;
    logic        stall, done, fault, bvalid, bwrite;
    logic [3:0]  bwstrb;

    logic        t_rd = 1'b0;
    logic [31:0] t_read_data, t_wdata, t_addr;
    logic        t_stall, t_done, t_fault, t_valid, t_write;
    logic [3:0]  t_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    // results of the last do_access call
    logic        a_done, a_stable, a_write, a_flt, a_done_after, a_valid_after;
    logic [31:0] a_addr, a_wdata, a_rd;
    logic [3:0]  a_wstrb;
    int          a_stall, a_valid;

    always #5 clk = ~clk;

    data_memory_controller u_dut (
        .clk(clk), .reset_n(reset_n),
        .memory_read(rd), .memory_write(wr), .address(addr),
        .write_data(wdata), .write_mask(mask), .misaligned(mis),
        .read_data(read_data), .stall(stall), .done(done), .access_fault(fault),
        .bus_req_valid(bvalid), .bus_req_ready(ready), .bus_req_write(bwrite),
        .bus_req_addr(baddr), .bus_req_wdata(bwdata), .bus_req_wstrb(bwstrb),
        .bus_resp_valid(rvalid), .bus_resp_rdata(rdata), .bus_resp_error(rerr)
    );

    // Second instance with a short timeout and a bus that never responds.
    data_memory_controller #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) u_to (
        .clk(clk), .reset_n(reset_n),
        .memory_read(t_rd), .memory_write(1'b0), .address(32'h0000_0040),
        .write_data(32'h0), .write_mask(4'b0000), .misaligned(1'b0),
        .read_data(t_read_data), .stall(t_stall), .done(t_done), .access_fault(t_fault),
        .bus_req_valid(t_valid), .bus_req_ready(1'b1), .bus_req_write(t_write),
        .bus_req_addr(t_addr), .bus_req_wdata(t_wdata), .bus_req_wstrb(t_wstrb),
        .bus_resp_valid(1'b0), .bus_resp_rdata(32'h0), .bus_resp_error(1'b0)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one access from the core and play the bus: ready after dly
    // valid cycles, single-cycle response in the cycle after acceptance.
    task automatic do_access(input logic i_rd, input logic i_wr, input logic i_mis,
                             input logic [31:0] i_addr, input logic [31:0] i_wdata,
                             input logic [3:0] i_mask, input int dly,
                             input logic [31:0] i_rdata, input logic i_err,
                             input int budget);
        logic acc;
        acc = 1'b0;
        a_done = 1'b0; a_stable = 1'b1; a_stall = 0; a_valid = 0;
        a_addr = '0; a_wdata = '0; a_wstrb = '0; a_write = 1'b0; a_rd = '0; a_flt = 1'b0;
        a_done_after = 1'b0; a_valid_after = 1'b0;
        rd = i_rd; wr = i_wr; mis = i_mis; addr = i_addr; wdata = i_wdata; mask = i_mask;
        ready = 1'b0; rvalid = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (done) begin
                a_done = 1'b1; a_rd = read_data; a_flt = fault;
                break;
            end
            if (stall) a_stall++;
            rvalid = acc; rdata = i_rdata; rerr = i_err;
            if (bvalid) begin
                a_valid++;
                if (a_valid == 1) begin
                    a_addr = baddr; a_wdata = bwdata; a_wstrb = bwstrb; a_write = bwrite;
                end else if (baddr !== a_addr || bwdata !== a_wdata ||
                             bwstrb !== a_wstrb || bwrite !== a_write) begin
                    a_stable = 1'b0;
                end
            end
            ready = bvalid && (a_valid > dly);
            acc   = bvalid && ready;
            @(posedge clk); #1;
        end
        if (a_done) begin
            // core keeps the instruction up through DONE and moves on at the edge
            @(posedge clk); #1;
        end
        rd = 1'b0; wr = 1'b0; mis = 1'b0; ready = 1'b0; rvalid = 1'b0; rerr = 1'b0;
        #1;
        a_done_after  = done;
        a_valid_after = bvalid;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic got;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", 64'({read_data, fault, stall, done, bvalid, bwrite, bwstrb}), 64'd0);
        check_eq("rst_bus", {baddr, bwdata}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_outs", 64'({read_data, fault, stall, done, bvalid}), 64'd0);

        // ---------------- load word ----------------
        do_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 20);
        check_eq("lw_done",   64'(a_done), 64'd1);
        check_eq("lw_addr",   64'(a_addr), 64'h100);
        check_eq("lw_wstrb",  64'(a_wstrb), 64'd0);
        check_eq("lw_write",  64'(a_write), 64'd0);
        check_eq("lw_stall",  64'(a_stall), 64'd3);
        check_eq("lw_rdata",  64'(a_rd), 64'hDEAD_BEEF);
        check_eq("lw_fault",  64'(a_flt), 64'd0);
        check_eq("lw_pulse",  64'(a_done_after), 64'd0);
        check_eq("lw_noreiss", 64'(a_valid_after), 64'd0);

        // ---------------- load byte ----------------
        do_access(1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 4'h0, 0, 32'h80FF_1234, 1'b0, 20);
        check_eq("lb_addr",  64'(a_addr), 64'h100);
        check_eq("lb_rdata", 64'(a_rd), 64'h80);

        // ---------------- store halfword, ready delayed ----------------
        do_access(1'b0, 1'b1, 1'b0, 32'h22, 32'hABCD_ABCD, 4'b1100, 3, 32'h5555_5555, 1'b0, 30);
        check_eq("sh_done",   64'(a_done), 64'd1);
        check_eq("sh_addr",   64'(a_addr), 64'h20);
        check_eq("sh_wstrb",  64'(a_wstrb), 64'hC);
        check_eq("sh_write",  64'(a_write), 64'd1);
        check_eq("sh_wdata",  64'(a_wdata), 64'hABCD_ABCD);
        check_eq("sh_stable", 64'(a_stable), 64'd1);
        check_eq("sh_vcyc",   64'(a_valid), 64'd4);
        check_eq("sh_stall",  64'(a_stall), 64'd6);
        check_eq("sh_keeprd", 64'(a_rd), 64'h80);

        // ---------------- accesses that never reach the bus ----------------
        do_access(1'b0, 1'b1, 1'b1, 32'h21, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 5);
        check_eq("mis_st", 64'({a_done, a_valid[7:0], a_stall[7:0]}), 64'd0);
        do_access(1'b1, 1'b0, 1'b1, 32'h41, 32'h0, 4'h0, 0, 32'h0, 1'b0, 5);
        check_eq("mis_ld", 64'({a_done, a_valid[7:0], a_stall[7:0]}), 64'd0);
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'h0, 0, 32'h0, 1'b0, 5);
        check_eq("st_mask0", 64'({a_done, a_valid[7:0], a_stall[7:0]}), 64'd0);

        // ---------------- read has priority over write ----------------
        do_access(1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 20);
        check_eq("prio_wr",    64'({a_write, a_wstrb}), 64'd0);
        check_eq("prio_rdata", 64'(a_rd), 64'hCAFE_F00D);

        // ---------------- bus error keeps previous read data ----------------
        do_access(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0000_0011, 1'b0, 20);
        check_eq("pre_rdata", 64'(a_rd), 64'h11);
        do_access(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b1, 20);
        check_eq("err_done",  64'(a_done), 64'd1);
        check_eq("err_fault", 64'(a_flt), 64'd1);
        check_eq("err_rdata", 64'(a_rd), 64'h11);

        // ---------------- fault clears on a good halfword load ----------------
        do_access(1'b1, 1'b0, 1'b0, 32'h2, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 20);
        check_eq("lh_rdata", 64'(a_rd), 64'h1234);
        check_eq("lh_fault", 64'(a_flt), 64'd0);

        // ---------------- timeout (limit 4, no response) ----------------
        t_rd = 1'b1;
        n = 0; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (t_done) begin got = 1'b1; break; end
            if (t_stall) n++;
            @(posedge clk); #1;
        end
        check_eq("to_done",  64'(got), 64'd1);
        check_eq("to_fault", 64'(t_fault), 64'd1);
        check_eq("to_rdata", 64'(t_read_data), 64'd0);
        check_eq("to_valid", 64'(t_valid), 64'd0);
        check_eq("to_stall", 64'(n), 64'd5);
        @(posedge clk); #1;
        t_rd = 1'b0;
        @(posedge clk); #1;

        // ---------------- reset while waiting for a response ----------------
        rd = 1'b1; addr = 32'h30; ready = 1'b1;
        @(posedge clk); #1;              // REQ, accepted on next edge
        @(posedge clk); #1;              // RESP
        ready = 1'b0;
        check_eq("rr_stall", 64'({stall, bvalid}), 64'h2);
        reset_n = 1'b0;
        #1;
        check_eq("rr_outs", 64'({read_data, fault, stall, done, bvalid, bwstrb}), 64'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rvalid = 1'b0;
        check_eq("rr_late_resp", 64'({read_data, done, stall, fault}), 64'd0);
        @(posedge clk); #1;
        check_eq("rr_idle", 64'({done, bvalid}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
